// File: rtl/traffic_light_sequencer.sv
// rtl/traffic_light_sequencer.sv - timed two-road phase sequencer with latched side request
module traffic_light_sequencer #(
    parameter int TICK_DIV         = 4,
    parameter int MAIN_MIN_GREEN   = 3,
    parameter int YELLOW_TICKS     = 2,
    parameter int SIDE_GREEN_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       hold,
    output logic [1:0] state,
    output logic       req_pending,
    output logic       phase_start
);

    // Longest phase count the timer must be able to hold
    localparam int MAX_A  = (MAIN_MIN_GREEN > YELLOW_TICKS) ? MAIN_MIN_GREEN : YELLOW_TICKS;
    localparam int MAX_T  = (MAX_A > SIDE_GREEN_TICKS) ? MAX_A : SIDE_GREEN_TICKS;
    localparam int TW     = $clog2(MAX_T + 1);
    // A divide-by-one prescaler still gets a 1-bit register that simply stays at 0
    localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] MAIN_MIN_T  = TW'(MAIN_MIN_GREEN);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_TICKS - 1);
    localparam logic [TW-1:0] SIDE_LAST   = TW'(SIDE_GREEN_TICKS - 1);

    typedef enum logic [1:0] {
        MAIN_GREEN  = 2'b00,
        MAIN_YELLOW = 2'b01,
        SIDE_GREEN  = 2'b10,
        SIDE_YELLOW = 2'b11
    } phase_t;

    phase_t        phase;
    logic [PW-1:0] presc;
    logic [TW-1:0] timer;
    logic          tick;

    assign state = phase;

    // Timing tick: last prescaler count of a non-frozen cycle
    assign tick = (presc == PRESC_LAST) && !hold;

    // Prescaler, phase timer, phase register, request latch and phase_start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= MAIN_GREEN;
            presc       <= '0;
            timer       <= '0;
            req_pending <= 1'b0;
            phase_start <= 1'b0;
        end else begin
            phase_start <= 1'b0;

            if (!hold) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            end

            // Requests keep latching during hold; side-green traffic is already being served
            if (side_req && (phase != SIDE_GREEN)) begin
                req_pending <= 1'b1;
            end

            if (tick) begin
                case (phase)
                    MAIN_GREEN: begin
                        if ((timer == MAIN_MIN_T) && req_pending) begin
                            phase       <= MAIN_YELLOW;
                            timer       <= '0;
                            phase_start <= 1'b1;
                        end else if (timer != MAIN_MIN_T) begin
                            timer <= timer + 1'b1;
                        end
                    end
                    MAIN_YELLOW: begin
                        if (timer == YELLOW_LAST) begin
                            phase       <= SIDE_GREEN;
                            timer       <= '0;
                            phase_start <= 1'b1;
                            // Entering side green serves the request; this beats a same-cycle set
                            req_pending <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    SIDE_GREEN: begin
                        if (timer == SIDE_LAST) begin
                            phase       <= SIDE_YELLOW;
                            timer       <= '0;
                            phase_start <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        if (timer == YELLOW_LAST) begin
                            phase       <= MAIN_GREEN;
                            timer       <= '0;
                            phase_start <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb/tb_traffic_light_sequencer.sv - directed self-checking bench for traffic_light_sequencer
module tb_traffic_light_sequencer;

    logic       clk;
    logic       rst;
    logic       side_req;
    logic       hold;
    logic [1:0] state;
    logic       req_pending;
    logic       phase_start;

    int checks;
    int failures;
    int cyc;
    int ps_cnt;
    int bad_state;

    traffic_light_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .side_req    (side_req),
        .hold        (hold),
        .state       (state),
        .req_pending (req_pending),
        .phase_start (phase_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge; afterwards outputs show the value of "cycle cyc"
    task automatic edge_once();
        @(posedge clk);
        #1;
        cyc++;
        if (phase_start === 1'b1) ps_cnt++;
        if (state !== 2'b00) bad_state++;
    endtask

    task automatic run_until(input int n);
        while (cyc < n) edge_once();
    endtask

    // side_req high for the single edge numbered n
    task automatic pulse_at(input int n);
        run_until(n);
        side_req = 1'b1;
        edge_once();
        side_req = 1'b0;
    endtask

    task automatic start_run();
        rst      = 1'b1;
        side_req = 1'b0;
        hold     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        cyc       = 0;
        ps_cnt    = 0;
        bad_state = 0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        ps_cnt    = 0;
        bad_state = 0;
        rst       = 1'b1;
        side_req  = 1'b0;
        hold      = 1'b0;

        // Reset values
        #12;
        chk("reset_state", 32'(state), 0);
        chk("reset_req", 32'(req_pending), 0);
        chk("reset_ps", 32'(phase_start), 0);

        // 1: no requests for 200 cycles
        start_run();
        run_until(200);
        chk("idle_state_never_left", 32'(bad_state), 0);
        chk("idle_state", 32'(state), 0);
        chk("idle_req", 32'(req_pending), 0);
        chk("idle_ps_count", 32'(ps_cnt), 0);

        // 2: early single-cycle request
        start_run();
        pulse_at(2);
        chk("early_req_c3", 32'(req_pending), 1);
        run_until(15);
        chk("early_state_c15", 32'(state), 0);
        run_until(16);
        chk("early_state_c16", 32'(state), 1);
        chk("early_ps_c16", 32'(phase_start), 1);
        run_until(17);
        chk("early_ps_c17", 32'(phase_start), 0);
        run_until(23);
        chk("early_state_c23", 32'(state), 1);
        run_until(24);
        chk("early_state_c24", 32'(state), 2);
        chk("early_req_c24", 32'(req_pending), 0);
        chk("early_ps_c24", 32'(phase_start), 1);
        run_until(43);
        chk("early_state_c43", 32'(state), 2);
        run_until(44);
        chk("early_state_c44", 32'(state), 3);
        chk("early_ps_c44", 32'(phase_start), 1);
        run_until(52);
        chk("early_state_c52", 32'(state), 0);
        chk("early_ps_c52", 32'(phase_start), 1);
        run_until(80);
        chk("early_ps_count", 32'(ps_cnt), 4);
        chk("early_state_c80", 32'(state), 0);

        // 3: late request after minimum green has elapsed
        start_run();
        pulse_at(30);
        chk("late_req_c31", 32'(req_pending), 1);
        chk("late_state_c31", 32'(state), 0);
        run_until(32);
        chk("late_state_c32", 32'(state), 1);

        // 4: requests during side phases
        start_run();
        pulse_at(2);
        run_until(26);
        side_req = 1'b1;
        run_until(31);
        side_req = 1'b0;
        chk("side10_req_ignored", 32'(req_pending), 0);
        chk("side10_state", 32'(state), 2);
        pulse_at(46);
        chk("side11_state_c47", 32'(state), 3);
        chk("side11_req_c47", 32'(req_pending), 1);
        run_until(52);
        chk("side11_state_c52", 32'(state), 0);
        chk("side11_req_c52", 32'(req_pending), 1);
        run_until(67);
        chk("side11_state_c67", 32'(state), 0);
        run_until(68);
        chk("side11_state_c68", 32'(state), 1);

        // 5: hold extension during side green
        start_run();
        pulse_at(2);
        run_until(28);
        hold = 1'b1;
        run_until(48);
        hold = 1'b0;
        chk("hold_state_c48", 32'(state), 2);
        chk("hold_ps_count_c48", 32'(ps_cnt), 2);
        run_until(63);
        chk("hold_state_c63", 32'(state), 2);
        run_until(64);
        chk("hold_state_c64", 32'(state), 3);
        chk("hold_ps_c64", 32'(phase_start), 1);
        chk("hold_ps_count_c64", 32'(ps_cnt), 3);

        // 6: asynchronous reset mid-phase
        start_run();
        pulse_at(2);
        run_until(30);
        chk("arst_pre_state", 32'(state), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_req", 32'(req_pending), 0);
        chk("arst_ps", 32'(phase_start), 0);
        @(negedge clk);
        rst       = 1'b0;
        cyc       = 0;
        ps_cnt    = 0;
        pulse_at(2);
        run_until(5);
        chk("arst2_req_set", 32'(req_pending), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst2_req_clear", 32'(req_pending), 0);
        @(negedge clk);
        rst    = 1'b0;
        cyc    = 0;
        ps_cnt = 0;
        pulse_at(2);
        run_until(15);
        chk("arst_resume_c15", 32'(state), 0);
        run_until(16);
        chk("arst_resume_c16", 32'(state), 1);
        run_until(24);
        chk("arst_resume_c24", 32'(state), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
